// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer for the SCC core: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives the datapath enables and counts retirements.
module cpu_control_fsm #(
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instr,
  input  logic [3:0]          flags,
  input  logic                dmem_ack,
  output logic                ir_load,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                pc_src,
  output logic                rf_we,
  output logic [2:0]          rf_wsel,
  output logic [2:0]          alu_op,
  output logic                alu_b_imm,
  output logic                flags_we,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                halted,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALTED} state_t;

  typedef enum logic [3:0] {
    CL_ALU, CL_LOAD, CL_STOR, CL_MOV, CL_MOVT, CL_CLR, CL_SET,
    CL_B, CL_BCOND, CL_BR, CL_NOP, CL_HALT, CL_ILLEGAL
  } class_t;

  typedef enum logic [2:0] {
    WSEL_ALU, WSEL_DMEM, WSEL_IMM_LO, WSEL_IMM_HI, WSEL_ZERO, WSEL_ONES
  } wsel_t;

  state_t     state, state_next;
  class_t     cls;
  logic [6:0] op;
  logic       s_bit;
  logic       retire;
  logic [2:0] exec_alu_op;
  logic       exec_b_imm;
  logic       instr_unused;

  assign op    = instr[31:25];
  // The S bit is the fourth opcode bit of the ALU patterns "001 S ooo" / "011 S ooo".
  assign s_bit = instr[28];

  // Operand fields are consumed by the datapath, not by the sequencer.
  assign instr_unused = ^instr[20:0];

  always_comb begin
    cls = CL_ILLEGAL;
    if (op[6:4] == 3'b001 && op[2:0] inside {[3'd1:3'd5]}) begin
      cls = CL_ALU;
    end else if (op[6:4] == 3'b011 && op[2:0] inside {[3'd1:3'd6]}) begin
      cls = CL_ALU;
    end else begin
      case (op)
        7'b1000000: cls = CL_LOAD;
        7'b1000001: cls = CL_STOR;
        7'b0000000: cls = CL_MOV;
        7'b0000001: cls = CL_MOVT;
        7'b0000010: cls = CL_CLR;
        7'b0000011: cls = CL_SET;
        7'b1100000: cls = CL_B;
        7'b1100001: cls = CL_BCOND;
        7'b1100010: cls = CL_BR;
        7'b1100100: cls = CL_NOP;
        7'b1101000: cls = CL_HALT;
        default:    cls = CL_ILLEGAL;
      endcase
    end
  end

  // ALU controls chosen in EXEC; reused in MEM and WB so address/result stay stable.
  always_comb begin
    exec_alu_op = 3'd0;
    exec_b_imm  = 1'b0;
    if (cls == CL_ALU) begin
      exec_alu_op = instr[27:25];
      exec_b_imm  = ~op[5];
    end else if (cls == CL_LOAD || cls == CL_STOR) begin
      exec_alu_op = 3'd1;
      exec_b_imm  = 1'b1;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    retire     = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    pc_src     = 1'b0;
    rf_we      = 1'b0;
    rf_wsel    = WSEL_ALU;
    alu_op     = 3'd0;
    alu_b_imm  = 1'b0;
    flags_we   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;
    // NOTE: outputs are qualified by rst_n so a mid-operation reset kills them at once.
    if (rst_n) begin
      case (state)
        FETCH: begin
          ir_load    = 1'b1;
          pc_inc     = 1'b1;
          state_next = DECODE;
        end
        DECODE: begin
          case (cls)
            CL_NOP: begin
              retire     = 1'b1;
              state_next = FETCH;
            end
            CL_HALT: begin
              retire     = 1'b1;
              state_next = HALTED;
            end
            CL_ILLEGAL: begin
              illegal    = 1'b1;
              retire     = 1'b1;
              state_next = FETCH;
            end
            default: state_next = EXEC;
          endcase
        end
        EXEC: begin
          alu_op    = exec_alu_op;
          alu_b_imm = exec_b_imm;
          case (cls)
            CL_LOAD, CL_STOR: state_next = MEM;
            CL_B, CL_BR, CL_BCOND: begin
              pc_load    = (cls != CL_BCOND) || ((instr[24:21] & flags) != 4'b0000);
              pc_src     = (cls == CL_BR);
              retire     = 1'b1;
              state_next = FETCH;
            end
            default: state_next = WB;
          endcase
        end
        MEM: begin
          alu_op    = exec_alu_op;
          alu_b_imm = exec_b_imm;
          dmem_req  = 1'b1;
          dmem_we   = (cls == CL_STOR);
          if (dmem_ack) begin
            if (cls == CL_STOR) begin
              retire     = 1'b1;
              state_next = FETCH;
            end else begin
              state_next = WB;
            end
          end
        end
        WB: begin
          alu_op     = exec_alu_op;
          alu_b_imm  = exec_b_imm;
          rf_we      = 1'b1;
          flags_we   = (cls == CL_ALU) && s_bit;
          retire     = 1'b1;
          state_next = FETCH;
          case (cls)
            CL_LOAD: rf_wsel = WSEL_DMEM;
            CL_MOV:  rf_wsel = WSEL_IMM_LO;
            CL_MOVT: rf_wsel = WSEL_IMM_HI;
            CL_CLR:  rf_wsel = WSEL_ZERO;
            CL_SET:  rf_wsel = WSEL_ONES;
            default: rf_wsel = WSEL_ALU;
          endcase
        end
        HALTED:  halted = 1'b1;
        default: state_next = FETCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      retired <= '0;
    end else begin
      state <= state_next;
      if (retire) retired <= retired + RETIRE_W'(1);
    end
  end

endmodule
